// File: rtl/uart_pkg.sv
// Shared definitions for the CPLD UART port: FSM encodings, status bit
// positions and the addresses the memory-stage decoder maps onto this block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        RD_STROBE = 3'd2,
        WR_SETUP  = 3'd3,
        WR_STROBE = 3'd4,
        WR_HOLD   = 3'd5,
        WR_GUARD  = 3'd6,
        WR_WAIT   = 3'd7
    } state_t;

    localparam int RX_READY_BIT = 1;
    localparam int TX_READY_BIT = 0;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

endpackage

// File: rtl/uart_port_sync_2ff.sv
// One-bit two-flop synchronizer for the asynchronous UART status pins.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_port.sv
// Byte-wide sequencer for the CPLD UART sharing RAM1 data[7:0]: runs the
// rdn/wrn strobes, drives/samples the shared bus and returns a one-cycle ack.
module uart_port
    import uart_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned GUARD_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       uart_active,
    output logic [1:0] status,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    output state_t     dbg_state
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] GUARD_LOAD  = 4'(GUARD_CYCLES);

    logic dr_s, tbre_s, tsre_s;

    sync_2ff u_sync_dr   (.clk(clk), .rst(rst), .d(data_ready), .q(dr_s));
    sync_2ff u_sync_tbre (.clk(clk), .rst(rst), .d(tbre),       .q(tbre_s));
    sync_2ff u_sync_tsre (.clk(clk), .rst(rst), .d(tsre),       .q(tsre_s));

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       rdn_nxt, wrn_nxt, oe_nxt, ack_nxt;
    logic [7:0] out_nxt, rdata_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdn     <= 1'b1;
            wrn     <= 1'b1;
            bus_oe  <= 1'b0;
            bus_out <= 8'h00;
            rdata   <= 8'h00;
            ack     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdn     <= rdn_nxt;
            wrn     <= wrn_nxt;
            bus_oe  <= oe_nxt;
            bus_out <= out_nxt;
            rdata   <= rdata_nxt;
            ack     <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdn_nxt   = rdn;
        wrn_nxt   = wrn;
        oe_nxt    = bus_oe;
        out_nxt   = bus_out;
        rdata_nxt = rdata;
        ack_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        out_nxt   = wdata;
                        state_nxt = WR_SETUP;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (dr_s) begin
                    rdn_nxt   = 1'b0;
                    cnt_nxt   = STROBE_LOAD;
                    state_nxt = RD_STROBE;
                end
            end
            RD_STROBE: begin
                if (cnt == 4'd0) begin
                    rdata_nxt = bus_in;
                    rdn_nxt   = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            // First cycle turns the bus driver on; the second drops wrn
            // so the data is stable on the pad before the strobe edge.
            WR_SETUP: begin
                if (!bus_oe) begin
                    oe_nxt = 1'b1;
                end else begin
                    wrn_nxt   = 1'b0;
                    cnt_nxt   = STROBE_LOAD;
                    state_nxt = WR_STROBE;
                end
            end
            WR_STROBE: begin
                if (cnt == 4'd0) begin
                    wrn_nxt   = 1'b1;
                    state_nxt = WR_HOLD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                oe_nxt    = 1'b0;
                cnt_nxt   = GUARD_LOAD;
                state_nxt = WR_GUARD;
            end
            // Gives the UART time to drop tbre/tsre and the synchronizers
            // time to carry that drop before the flags are trusted.
            WR_GUARD: begin
                if (cnt <= 4'd1) begin
                    state_nxt = WR_WAIT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WR_WAIT: begin
                if (tbre_s && tsre_s) begin
                    ack_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign uart_active = busy;
    assign dbg_state   = state;

    always_comb begin
        status               = 2'b00;
        status[RX_READY_BIT] = dr_s;
        status[TX_READY_BIT] = tbre_s & tsre_s & (state == IDLE);
    end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port: reset, reads, writes, mid-write reset,
// ignored requests and back-to-back reads, all at default parameters.
module tb_uart_port;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst, req, we, ack, busy, uart_active, bus_oe;
    logic       data_ready, tbre, tsre, rdn, wrn;
    logic [7:0] wdata, rdata, bus_out, bus_in;
    logic [1:0] status;
    state_t     dbg_state;

    int vectors = 0;
    int errors  = 0;

    uart_port #(.STROBE_CYCLES(2), .GUARD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .uart_active(uart_active),
        .status(status), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
        .rdn(rdn), .wrn(wrn), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Bus-safety invariants, checked every cycle
    always @(negedge clk) begin
        vectors++;
        if (bus_oe && !rdn) begin
            errors++;
            $display("FAIL oe_vs_rdn: bus_oe=%b rdn=%b, required not both active", bus_oe, rdn);
        end
        vectors++;
        if (!rdn && !wrn) begin
            errors++;
            $display("FAIL strobe_overlap: rdn=%b wrn=%b, required not both low", rdn, wrn);
        end
    end

    task automatic test_reset();
        rst = 1'b0; req = 1'b1; we = 1'b0; wdata = 8'hAA; bus_in = 8'hFF;
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({rdn, wrn, bus_oe, ack, busy, uart_active} !== 6'b110000) begin
                errors++;
                $display("FAIL reset_ctl: got %b required 110000", {rdn, wrn, bus_oe, ack, busy, uart_active});
            end
            vectors++;
            if ({bus_out, rdata, status} !== 18'h0) begin
                errors++;
                $display("FAIL reset_data: got %h required 0", {bus_out, rdata, status});
            end
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        rst = 1'b1; req = 1'b0;
        repeat (3) tick();
        vectors++;
        if (status !== 2'b11) begin
            errors++;
            $display("FAIL idle_status: got %b required 11", status);
        end
    endtask

    task automatic test_read_ready();
        logic [2:0] exp_rdn = 3'b100;   // index k-1 for k=1..3
        bus_in = 8'h5A; req = 1'b1; we = 1'b0;
        tick();
        req = 1'b0;
        vectors++;
        if (busy !== 1'b1 || rdn !== 1'b1) begin
            errors++;
            $display("FAIL rd_accept: busy=%b rdn=%b required busy=1 rdn=1", busy, rdn);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (rdn !== ((k == 4) ? 1'b1 : exp_rdn[k-1])) begin
                errors++;
                $display("FAIL rd_rdn_k%0d: got %b", k, rdn);
            end
            vectors++;
            if (ack !== (k == 3) || busy !== (k < 3) || bus_oe !== 1'b0) begin
                errors++;
                $display("FAIL rd_ctl_k%0d: ack=%b busy=%b oe=%b", k, ack, busy, bus_oe);
            end
            if (k < 3) begin
                vectors++;
                if (status !== 2'b10) begin
                    errors++;
                    $display("FAIL rd_busy_status_k%0d: got %b required 10", k, status);
                end
            end
        end
        vectors++;
        if (rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rd_data: got %h required 5a", rdata);
        end
    endtask

    task automatic test_read_wait();
        data_ready = 1'b0; bus_in = 8'hC3;
        repeat (3) tick();
        vectors++;
        if (status !== 2'b01) begin
            errors++;
            $display("FAIL rx_empty_status: got %b required 01", status);
        end
        req = 1'b1; we = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            vectors++;
            if (rdn !== 1'b1 || busy !== 1'b1 || uart_active !== 1'b1 || ack !== 1'b0) begin
                errors++;
                $display("FAIL rdwait_hold_%0d: rdn=%b busy=%b act=%b ack=%b", i, rdn, busy, uart_active, ack);
            end
        end
        data_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            vectors++;
            if (rdn !== (j <= 2 || j == 5) || ack !== (j == 5) || busy !== (j < 5)) begin
                errors++;
                $display("FAIL rdwait_strobe_%0d: rdn=%b ack=%b busy=%b", j, rdn, ack, busy);
            end
        end
        vectors++;
        if (rdata !== 8'hC3) begin
            errors++;
            $display("FAIL rdwait_data: got %h required c3", rdata);
        end
    endtask

    task automatic test_write();
        int acks = 0;
        wdata = 8'h41; req = 1'b1; we = 1'b1;
        tick();
        req = 1'b0; wdata = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            tick();
            acks += int'(ack);
            vectors++;
            if (bus_oe !== (k <= 4) || wrn !== !(k == 2 || k == 3) || rdn !== 1'b1) begin
                errors++;
                $display("FAIL wr_strobe_k%0d: oe=%b wrn=%b rdn=%b", k, bus_oe, wrn, rdn);
            end
            vectors++;
            if (ack !== (k == 15) || busy !== (k < 15) || uart_active !== busy) begin
                errors++;
                $display("FAIL wr_ack_k%0d: ack=%b busy=%b act=%b", k, ack, busy, uart_active);
            end
            if (k <= 4) begin
                vectors++;
                if (bus_out !== 8'h41) begin
                    errors++;
                    $display("FAIL wr_bus_k%0d: got %h required 41", k, bus_out);
                end
            end
            if (k == 4) begin tbre = 1'b0; tsre = 1'b0; end
            if (k == 9) tbre = 1'b1;
            if (k == 12) tsre = 1'b1;
        end
        vectors++;
        if (acks !== 1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL wr_done: acks=%0d state=%0d required 1 and IDLE", acks, dbg_state);
        end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        wdata = 8'h99; req = 1'b1; we = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        vectors++;
        if (wrn !== 1'b0 || bus_oe !== 1'b1) begin
            errors++;
            $display("FAIL midwr_pre: wrn=%b oe=%b required 0 and 1", wrn, bus_oe);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({wrn, rdn, bus_oe, ack, busy} !== 5'b11000 || bus_out !== 8'h00 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL midwr_reset: ctl=%b out=%h state=%0d", {wrn, rdn, bus_oe, ack, busy}, bus_out, dbg_state);
        end
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            acks += int'(ack);
        end
        vectors++;
        if (acks !== 0 || wrn !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL midwr_after: acks=%0d wrn=%b state=%0d required 0,1,IDLE", acks, wrn, dbg_state);
        end
    endtask

    task automatic test_ignored_req();
        int acks = 0;
        int wr_lows = 0;
        tbre = 1'b0;
        repeat (3) tick();
        wdata = 8'h55; req = 1'b1; we = 1'b1;
        tick();
        req = 1'b0;
        repeat (9) tick();
        vectors++;
        if (dbg_state !== WR_WAIT) begin
            errors++;
            $display("FAIL ign_wait: state=%0d required %0d", dbg_state, WR_WAIT);
        end
        wdata = 8'h77; req = 1'b1; we = 1'b1;
        tick();
        req = 1'b0; tbre = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            acks += int'(ack);
            wr_lows += int'(!wrn);
        end
        vectors++;
        if (acks !== 1 || wr_lows !== 0 || bus_out !== 8'h55) begin
            errors++;
            $display("FAIL ign_once: acks=%0d wrn_lows=%0d out=%h required 1,0,55", acks, wr_lows, bus_out);
        end
    endtask

    task automatic test_back_to_back();
        bus_in = 8'h11; req = 1'b1; we = 1'b0;
        tick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            vectors++;
            if (ack !== (k == 3 || k == 7) || busy !== !(k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b_k%0d: ack=%b busy=%b", k, ack, busy);
            end
            if (k == 3) begin
                vectors++;
                if (rdata !== 8'h11) begin
                    errors++;
                    $display("FAIL b2b_first: got %h required 11", rdata);
                end
                bus_in = 8'h22;
            end
            if (k == 4) req = 1'b0;
        end
        vectors++;
        if (rdata !== 8'h22) begin
            errors++;
            $display("FAIL b2b_second: got %h required 22", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_ready();
        test_read_wait();
        test_write();
        test_reset_mid_write();
        test_ignored_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_port.md
# uart_port

Byte-wide controller for the board's CPLD-attached UART, which shares the low byte of the RAM1 data bus. It sits directly downstream of the memory stage: that stage decodes the UART data and status addresses and issues single read/write requests here. This block sequences `rdn`/`wrn`, drives and samples the shared bus, and returns a one-cycle `ack`. It also holds `uart_active` high so the memory stage keeps RAM1 disabled for the whole access.

## Interface
Parameters:
- `STROBE_CYCLES`, default 2: number of cycles `rdn`/`wrn` are held low; legal range 1–15.
- `GUARD_CYCLES`, default 3: cycles after `wrn` release before `tbre`/`tsre` are evaluated; must be at least the synchronizer depth plus 1.

Ports (clock and reset first):
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `req`, in, 1: access request; sampled only in IDLE.
- `we`, in, 1: 1 = write, 0 = read; qualifies `req`.
- `wdata`, in, 8: transmit byte; captured when `req` is accepted.
- `rdata`, out, 8: received byte; valid from `ack` until the next accepted read.
- `ack`, out, 1: one-cycle completion pulse.
- `busy`, out, 1: high in any non-IDLE state; the memory stage stalls the pipeline on it.
- `uart_active`, out, 1: equals `busy`; forces RAM1 `en`/`oe`/`we` inactive.
- `status`, out, 2: {`rx_ready`, `tx_ready`}; value returned for the status address.
- `bus_out`, out, 8: byte driven onto `ram1_data[7:0]`.
- `bus_oe`, out, 1: tristate enable for `bus_out`.
- `bus_in`, in, 8: `ram1_data[7:0]` as seen at the pad.
- `data_ready`, `tbre`, `tsre`, in, 1 each: asynchronous UART status pins.
- `rdn`, `wrn`, out, 1 each: active-low UART strobes.

## Operation
- `data_ready`, `tbre` and `tsre` each pass through a 2-flop synchronizer, producing `dr_s`, `tbre_s`, `tsre_s`.
- `status[1]` = `dr_s`.
- `status[0]` = `tbre_s & tsre_s & (state==IDLE)`.
- FSM states and transitions:
  - IDLE: on `req & ~we`, go to RD_WAIT. On `req & we`, go to WR_SETUP and capture `wdata`.
  - RD_WAIT: while `dr_s`=0, stay and keep `rdn`=1. When `dr_s`=1, go to RD_STROBE with `rdn`<=0 and the counter loaded to `STROBE_CYCLES`-1.
  - RD_STROBE: decrement the counter. When it reaches 0: `rdata`<=`bus_in`, `rdn`<=1, `ack`<=1, go to IDLE.
  - WR_SETUP: `bus_oe`=1 and `bus_out`=captured byte for 1 cycle, then `wrn`<=0 and go to WR_STROBE.
  - WR_STROBE: count `STROBE_CYCLES`, then `wrn`<=1 and go to WR_HOLD.
  - WR_HOLD: keep `bus_oe` for 1 cycle, then `bus_oe`<=0, load the counter with `GUARD_CYCLES`, go to WR_GUARD.
  - WR_GUARD: count down, then go to WR_WAIT.
  - WR_WAIT: when `tbre_s & tsre_s`, set `ack`<=1 and go to IDLE.
- `req` outside IDLE is ignored, not queued. The memory stage re-issues after `ack`.
- A read with no byte available waits indefinitely; there is no timeout.
- `bus_oe` is never high while `rdn`=0. `rdn` and `wrn` are never both low.

## Timing
- Reset values: `rdn`=1, `wrn`=1, `bus_oe`=0, `bus_out`=0, `rdata`=0, `ack`=0, `busy`=0, `uart_active`=0, state=IDLE, synchronizer flops=0.
- Reset mid-operation: on the next edge all outputs return to their reset values. Any partial write is abandoned and no `ack` is produced.
- Read, with `dr_s` already 1 and `req` sampled at edge 0:
  - `rdn` is low from edge 1 to edge `STROBE_CYCLES`+1.
  - `ack` is high and `rdata` is valid after edge `STROBE_CYCLES`+1. With the default this is edge 3.
- Write, with `req` sampled at edge 0:
  - `bus_oe` rises at edge 1.
  - `wrn` is low from edge 2 to edge 2+`STROBE_CYCLES`.
  - `bus_oe` falls at edge 3+`STROBE_CYCLES`.
  - `ack` comes no earlier than edge 3+`STROBE_CYCLES`+`GUARD_CYCLES`+1, and only once both synchronized flags are 1.
- The synchronizers add 2 cycles from an async pin to `status` and to FSM decisions.
- `busy` is high from the edge that accepts `req` through the edge that asserts `ack`. `busy` is 0 in the `ack` cycle, so back-to-back requests are possible.

## Structure
- The shared package `uart_pkg` holds:
  - state encodings (3-bit);
  - `status` bit positions (`RX_READY_BIT`=1, `TX_READY_BIT`=0);
  - the UART data and status addresses (0xBF00 and 0xBF01), which are consumed by the memory stage's decoder.
- One sub-module, `sync_2ff`: a 1-bit two-flop synchronizer with synchronous active-low reset, instantiated three times.
- The counter is 4 bits, shared between the strobe and guard phases.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `req`=1 -> all outputs stay at their reset values; `rdn`=`wrn`=1 throughout.
- Read ready: `data_ready`=1 for ≥2 cycles, `bus_in`=0x5A, read `req` -> `rdn` low for exactly 2 cycles, then `ack`=1 for 1 cycle with `rdata`=0x5A; `bus_oe` is never 1.
- Read wait: read `req` with `data_ready`=0, then raise it 10 cycles later -> `rdn` stays 1 until 2 cycles after the rise, then follows the normal strobe; `busy` is 1 throughout.
- Write: write `req` with `wdata`=0x41; `tbre` low for 5 cycles after `wrn` rises, `tsre` low for 8 -> `bus_out`=0x41 with `bus_oe` covering the whole `wrn` low window; `ack` only after `tsre_s`=1.
- Reset mid-write: assert `rst` while `wrn`=0 -> next edge `wrn`=1, `bus_oe`=0, state IDLE, no `ack`.
- Ignored request: pulse `req` during WR_WAIT -> no second access; exactly one `ack`.
